dst_port_buffer: RTL and testbench

- Sits directly downstream of the packet router's destination interface.
- Accepts routed beats (`dst_valid`/`dst_ready`, carrying address, type, payload and end-of-packet flag) into one FIFO per destination address.
- Acknowledges each completed packet.
- Drains the FIFOs to a single output channel using packet-locked round-robin arbitration, so beats of different packets never interleave on the output.

---
 rtl/dst_buf_pkg.sv | 42 ++++
 rtl/dst_fifo.sv | 76 +++++++
 rtl/dst_port_buffer.sv | 158 +++++++++++++++
 tb/tb_dst_port_buffer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dst_buf_pkg.sv
// ----------------------------------------------------------------------------
// dst_buf_pkg
//   Shared types and constants for the destination port buffer.
//   - NUM_PORTS / ADDR_W : four destination queues, 2-bit address
//   - DATA_W / TYPE_W    : beat payload width and packet type width
//   - buf_entry_t        : one queued beat {pack_t, payload, eop}
//   - arb_state_t        : output arbiter state (IDLE / LOCK)
//   - rr_pick()          : round-robin selection starting after 'last'
// ----------------------------------------------------------------------------
package dst_buf_pkg;

    localparam int NUM_PORTS = 4;
    localparam int ADDR_W    = 2;
    localparam int DATA_W    = 8;
    localparam int TYPE_W    = 2;

    typedef struct packed {
        logic [TYPE_W-1:0] pack_t;
        logic [DATA_W-1:0] payload;
        logic              eop;
    } buf_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Scan last+1, last+2, ... (mod NUM_PORTS). The loop runs from the
    // farthest candidate to the nearest so the nearest requester wins.
    function automatic logic [ADDR_W-1:0] rr_pick(input logic [ADDR_W-1:0]    last,
                                                  input logic [NUM_PORTS-1:0] req);
        logic [ADDR_W-1:0] idx;
        rr_pick = last;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = last + ADDR_W'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/dst_fifo.sv
// ----------------------------------------------------------------------------
// dst_fifo
//   Single-clock FIFO holding buf_entry_t beats for one destination port.
//   Ports:
//     clk, reset      : clock, asynchronous active-low reset
//     wr_en, wr_data  : push one entry (caller guarantees !full)
//     rd_en, rd_data  : pop the head entry (caller guarantees !empty);
//                       rd_data always shows the current head
//     full, empty     : occupancy flags
//   Parameter DEPTH: entries, power of two, >= 2.
// ----------------------------------------------------------------------------
module dst_fifo
    import dst_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  buf_entry_t wr_data,
    input  logic       rd_en,
    output buf_entry_t rd_data,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_B = PTR_W + 1;

    buf_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_B-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && rd_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CNT_B'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/dst_port_buffer.sv
// ----------------------------------------------------------------------------
// dst_port_buffer
//   Buffers routed beats into one FIFO per destination port and drains them
//   onto a single output channel with packet-locked round-robin arbitration.
//   Ports:
//     clk, reset                      : clock, asynchronous active-low reset
//     dst_valid/dst_ready             : inbound handshake
//     dst_addr, pack_t, payload, eop  : inbound beat
//     ack                             : 1-cycle pulse after each accepted eop
//     out_valid/out_ready             : outbound handshake
//     out_port, out_pack_t, out_data,
//     out_eop                         : outbound beat and its source queue
//     pkt_cnt                         : per-port completed-packet counters,
//                                       port p at [p*CNT_W +: CNT_W]
//   Build option: define DST_BUF_STATS_EN to add pkt_cnt and its counters.
// ----------------------------------------------------------------------------
module dst_port_buffer
    import dst_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dst_valid,
    output logic              dst_ready,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [TYPE_W-1:0] pack_t,
    input  logic [DATA_W-1:0] payload,
    input  logic              eop,
    output logic              ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_port,
    output logic [TYPE_W-1:0] out_pack_t,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eop
`ifdef DST_BUF_STATS_EN
    ,
    output logic [NUM_PORTS*CNT_W-1:0] pkt_cnt
`endif
);

    logic [NUM_PORTS-1:0] full, empty, wr_en, rd_en;
    buf_entry_t           wr_entry;
    buf_entry_t           rd_entry [NUM_PORTS];
    buf_entry_t           head;
    logic                 accept, xfer;

    arb_state_t           state_q, state_d;
    logic [ADDR_W-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]    last_q, last_d;
    logic                 ack_q;

    assign wr_entry = '{pack_t: pack_t, payload: payload, eop: eop};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
        dst_fifo #(
            .DEPTH   (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en[p]),
            .wr_data (wr_entry),
            .rd_en   (rd_en[p]),
            .rd_data (rd_entry[p]),
            .full    (full[p]),
            .empty   (empty[p])
        );
    end

    // A full queue refuses a beat even if it is being drained this cycle.
    assign dst_ready = !full[dst_addr];
    assign accept    = dst_valid && dst_ready;

    assign head      = rd_entry[grant_q];
    assign out_valid = (state_q == LOCK) && !empty[grant_q];
    assign xfer      = out_valid && out_ready;

    always_comb begin
        wr_en = '0;
        rd_en = '0;
        if (accept) begin
            wr_en[dst_addr] = 1'b1;
        end
        if (xfer) begin
            rd_en[grant_q] = 1'b1;
        end
    end

    // The queue head is only meaningful while out_valid; zero it otherwise
    // so stale storage never leaks onto the output.
    assign out_port   = grant_q;
    assign out_pack_t = out_valid ? head.pack_t  : '0;
    assign out_data   = out_valid ? head.payload : '0;
    assign out_eop    = out_valid ? head.eop     : 1'b0;
    assign ack        = ack_q;

    // LOCK holds the grant until the eop beat leaves, even when the granted
    // queue runs dry mid-packet, so packets never interleave.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|(~empty)) begin
                    grant_d = rr_pick(last_q, ~empty);
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (xfer && head.eop) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last resets to the highest port so port 0 has first priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ADDR_W'(NUM_PORTS - 1);
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ack_q   <= accept && eop;
        end
    end

`ifdef DST_BUF_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_PORTS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                cnt_q[p] <= '0;
            end
        end else if (xfer && head.eop) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pkt_cnt[p*CNT_W +: CNT_W] = cnt_q[p];
        end
    end
`endif

endmodule

// File: tb/tb_dst_port_buffer.sv
module tb_dst_port_buffer;

    localparam int CNT_W = 16;

    logic       clk;
    logic       reset;
    logic       dst_valid;
    logic       dst_ready;
    logic [1:0] dst_addr;
    logic [1:0] pack_t;
    logic [7:0] payload;
    logic       eop;
    logic       ack;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_port;
    logic [1:0] out_pack_t;
    logic [7:0] out_data;
    logic       out_eop;
`ifdef DST_BUF_STATS_EN
    logic [4*CNT_W-1:0] pkt_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [10:0] log_q [$];
    int          cyc_q [$];

    dst_port_buffer #(
        .DEPTH      (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dst_valid  (dst_valid),
        .dst_ready  (dst_ready),
        .dst_addr   (dst_addr),
        .pack_t     (pack_t),
        .payload    (payload),
        .eop        (eop),
        .ack        (ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_port   (out_port),
        .out_pack_t (out_pack_t),
        .out_data   (out_data),
        .out_eop    (out_eop)
`ifdef DST_BUF_STATS_EN
        ,
        .pkt_cnt    (pkt_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change 1 time unit after a rising edge, so a handshake seen
    // at the falling edge is exactly the one completed at the next rising edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            log_q.push_back({out_port, out_eop, out_data});
            cyc_q.push_back(cyc);
        end
    end

    task automatic to_phase();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] a, input logic [1:0] t,
                        input logic [7:0] d, input logic e);
        dst_addr  = a;
        pack_t    = t;
        payload   = d;
        eop       = e;
        dst_valid = 1'b1;
        to_phase();
        dst_valid = 1'b0;
        eop       = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        to_phase();
        to_phase();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        to_phase();
        to_phase();
        checks++; if (dst_ready !== 1'b1) begin failures++; $display("FAIL rst_dst_ready got=%0h exp=1", dst_ready); end
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%0h exp=0", ack); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
        checks++; if ({out_port, out_pack_t, out_data, out_eop} !== 13'h0) begin failures++; $display("FAIL rst_out_fields got=%0h exp=0", {out_port, out_pack_t, out_data, out_eop}); end
`ifdef DST_BUF_STATS_EN
        checks++; if (pkt_cnt !== '0) begin failures++; $display("FAIL rst_pkt_cnt got=%0h exp=0", pkt_cnt); end
`endif
        reset = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_release_valid got=%0h exp=0", out_valid); end
        to_phase();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        push(2'd2, 2'd1, 8'hA5, 1'b1);
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL single_ack_hi got=%0h exp=1", ack); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_early got=%0h exp=0", out_valid); end
        to_phase();
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL single_ack_lo got=%0h exp=0", ack); end
        checks++; if ({out_valid, out_port, out_pack_t, out_data, out_eop} !== {1'b1, 2'd2, 2'd1, 8'hA5, 1'b1})
            begin failures++; $display("FAIL single_out got=%0h exp=%0h", {out_valid, out_port, out_pack_t, out_data, out_eop}, {1'b1, 2'd2, 2'd1, 8'hA5, 1'b1}); end
        to_phase();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_done got=%0h exp=0", out_valid); end
`ifdef DST_BUF_STATS_EN
        checks++; if (pkt_cnt[2*CNT_W +: CNT_W] !== 16'd1) begin failures++; $display("FAIL single_pkt_cnt got=%0d exp=1", pkt_cnt[2*CNT_W +: CNT_W]); end
`endif
        to_phase();
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(2'd1, 2'd0, 8'h10 + 8'(i), 1'b0);
        dst_addr = 2'd1;
        #1;
        checks++; if (dst_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_full got=%0h exp=0", dst_ready); end
        dst_addr = 2'd3;
        #1;
        checks++; if (dst_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_other got=%0h exp=1", dst_ready); end
        push(2'd1, 2'd0, 8'h14, 1'b1);
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL fill_refused_ack got=%0h exp=0", ack); end
        to_phase();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({out_valid, out_port, out_data, out_eop} !== {1'b1, 2'd1, 8'h10 + 8'(i), 1'b0})
                begin failures++; $display("FAIL fill_drain%0d got=%0h exp=%0h", i, {out_valid, out_port, out_data, out_eop}, {1'b1, 2'd1, 8'h10 + 8'(i), 1'b0}); end
            to_phase();
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_fifth_dropped got=%0h exp=0", out_valid); end
        to_phase();
        push(2'd1, 2'd2, 8'h15, 1'b1);
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL fill_eop_ack got=%0h exp=1", ack); end
        checks++; if ({out_valid, out_pack_t, out_data, out_eop} !== {1'b1, 2'd2, 8'h15, 1'b1})
            begin failures++; $display("FAIL fill_eop_out got=%0h exp=%0h", {out_valid, out_pack_t, out_data, out_eop}, {1'b1, 2'd2, 8'h15, 1'b1}); end
        to_phase();
    endtask

    task automatic test_lock();
        logic [10:0] exp_l [4];
        logic [10:0] got;
        exp_l = '{{2'd0, 1'b0, 8'h20}, {2'd0, 1'b0, 8'h21}, {2'd0, 1'b1, 8'h22}, {2'd1, 1'b1, 8'h30}};
        log_q.delete();
        cyc_q.delete();
        out_ready = 1'b1;
        push(2'd0, 2'd0, 8'h20, 1'b0);
        push(2'd0, 2'd0, 8'h21, 1'b0);
        push(2'd1, 2'd0, 8'h30, 1'b1);
        @(negedge clk);
        checks++; if ({out_valid, out_data} !== {1'b1, 8'h21}) begin failures++; $display("FAIL lock_beat2 got=%0h exp=%0h", {out_valid, out_data}, {1'b1, 8'h21}); end
        to_phase();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lock_hold%0d got=%0h exp=0", i, out_valid); end
            to_phase();
        end
        push(2'd0, 2'd0, 8'h22, 1'b1);
        @(negedge clk);
        checks++; if ({out_valid, out_port, out_data} !== {1'b1, 2'd0, 8'h22}) begin failures++; $display("FAIL lock_beat3 got=%0h exp=%0h", {out_valid, out_port, out_data}, {1'b1, 2'd0, 8'h22}); end
        repeat (4) to_phase();
        checks++; if (log_q.size() !== 4) begin failures++; $display("FAIL lock_count got=%0d exp=4", log_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < log_q.size()) ? log_q[i] : 11'h7FF;
            checks++; if (got !== exp_l[i]) begin failures++; $display("FAIL lock_seq%0d got=%0h exp=%0h", i, got, exp_l[i]); end
        end
        if (cyc_q.size() == 4) begin
            checks++; if (cyc_q[3] - cyc_q[2] !== 2) begin failures++; $display("FAIL lock_bubble got=%0d exp=2", cyc_q[3] - cyc_q[2]); end
        end
    endtask

    task automatic test_round_robin();
        logic [10:0] exp_l [3];
        logic [10:0] got;
        exp_l = '{{2'd0, 1'b1, 8'h40}, {2'd1, 1'b1, 8'h41}, {2'd3, 1'b1, 8'h43}};
        do_reset();
        out_ready = 1'b0;
        log_q.delete();
        cyc_q.delete();
        push(2'd0, 2'd0, 8'h40, 1'b1);
        push(2'd3, 2'd0, 8'h43, 1'b1);
        push(2'd1, 2'd0, 8'h41, 1'b1);
        out_ready = 1'b1;
        repeat (8) to_phase();
        checks++; if (log_q.size() !== 3) begin failures++; $display("FAIL rr_count got=%0d exp=3", log_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < log_q.size()) ? log_q[i] : 11'h7FF;
            checks++; if (got !== exp_l[i]) begin failures++; $display("FAIL rr_seq%0d got=%0h exp=%0h", i, got, exp_l[i]); end
        end
        if (cyc_q.size() == 3) begin
            checks++; if (cyc_q[1] - cyc_q[0] !== 2) begin failures++; $display("FAIL rr_gap01 got=%0d exp=2", cyc_q[1] - cyc_q[0]); end
            checks++; if (cyc_q[2] - cyc_q[1] !== 2) begin failures++; $display("FAIL rr_gap12 got=%0d exp=2", cyc_q[2] - cyc_q[1]); end
        end
`ifdef DST_BUF_STATS_EN
        checks++; if (pkt_cnt !== {16'd1, 16'd0, 16'd1, 16'd1}) begin failures++; $display("FAIL rr_pkt_cnt got=%0h exp=%0h", pkt_cnt, {16'd1, 16'd0, 16'd1, 16'd1}); end
`endif
    endtask

    task automatic test_backpressure();
        logic [10:0] got;
        out_ready = 1'b0;
        log_q.delete();
        cyc_q.delete();
        for (int i = 0; i < 4; i++) push(2'd2, 2'd3, 8'h50 + 8'(i), (i == 3));
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'b0;
            @(negedge clk);
            checks++; if ({out_valid, out_data} !== {1'b1, 8'h50 + 8'(k)}) begin failures++; $display("FAIL bp_stall%0d got=%0h exp=%0h", k, {out_valid, out_data}, {1'b1, 8'h50 + 8'(k)}); end
            to_phase();
            out_ready = 1'b1;
            @(negedge clk);
            checks++; if ({out_valid, out_pack_t, out_data} !== {1'b1, 2'd3, 8'h50 + 8'(k)}) begin failures++; $display("FAIL bp_held%0d got=%0h exp=%0h", k, {out_valid, out_pack_t, out_data}, {1'b1, 2'd3, 8'h50 + 8'(k)}); end
            to_phase();
        end
        out_ready = 1'b0;
        checks++; if (log_q.size() !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", log_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < log_q.size()) ? log_q[i] : 11'h7FF;
            checks++; if (got !== {2'd2, (i == 3), 8'h50 + 8'(i)}) begin failures++; $display("FAIL bp_seq%0d got=%0h exp=%0h", i, got, {2'd2, (i == 3), 8'h50 + 8'(i)}); end
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] got;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(2'd2, 2'd1, 8'h60 + 8'(i), 1'b0);
        #2;
        checks++; if ({out_valid, out_port, out_data} !== {1'b1, 2'd2, 8'h60}) begin failures++; $display("FAIL ar_pre got=%0h exp=%0h", {out_valid, out_port, out_data}, {1'b1, 2'd2, 8'h60}); end
        reset = 1'b0;
        #1;
        checks++; if ({out_valid, out_port, out_pack_t, out_data, out_eop} !== 14'h0) begin failures++; $display("FAIL ar_outputs got=%0h exp=0", {out_valid, out_port, out_pack_t, out_data, out_eop}); end
        checks++; if (dst_ready !== 1'b1) begin failures++; $display("FAIL ar_dst_ready got=%0h exp=1", dst_ready); end
`ifdef DST_BUF_STATS_EN
        checks++; if (pkt_cnt !== '0) begin failures++; $display("FAIL ar_pkt_cnt got=%0h exp=0", pkt_cnt); end
`endif
        to_phase();
        to_phase();
        reset = 1'b1;
        out_ready = 1'b1;
        log_q.delete();
        cyc_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({out_valid, ack} !== 2'b00) begin failures++; $display("FAIL ar_quiet%0d got=%0h exp=0", i, {out_valid, ack}); end
            to_phase();
        end
        push(2'd0, 2'd0, 8'h70, 1'b1);
        repeat (4) to_phase();
        checks++; if (log_q.size() !== 1) begin failures++; $display("FAIL ar_count got=%0d exp=1", log_q.size()); end
        got = (log_q.size() > 0) ? log_q[0] : 11'h7FF;
        checks++; if (got !== {2'd0, 1'b1, 8'h70}) begin failures++; $display("FAIL ar_new_pkt got=%0h exp=%0h", got, {2'd0, 1'b1, 8'h70}); end
    endtask

    initial begin
        reset     = 1'b1;
        dst_valid = 1'b0;
        dst_addr  = 2'd0;
        pack_t    = 2'd0;
        payload   = 8'h00;
        eop       = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_lock();
        test_round_robin();
        test_backpressure();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
